// File: rtl/accum_pkg.sv
// Shared types and defaults for the framed adder/accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned ACC_W_DEF = WIDTH_DEF + 1 + CNT_W_DEF;

  // Clamp value for the default accumulator width.
  localparam logic [ACC_W_DEF-1:0] ACC_SAT_VAL = {ACC_W_DEF{1'b1}};

endpackage

// File: rtl/accum_sat_add.sv
// Accumulator adder with carry-out detection.
// ACCUM_SAT_EN: when defined, results that carry out clamp to all-ones;
// otherwise the result wraps modulo 2**ACC_W.
module accum_sat_add #(
  parameter int unsigned ACC_W = 13
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] s,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] SAT_VAL = {ACC_W{1'b1}};

  logic [ACC_W:0] wide;

  assign wide = {1'b0, acc} + {1'b0, s};
  assign ovf  = wide[ACC_W];

`ifdef ACCUM_SAT_EN
  // Clamp on carry; an already-clamped acc plus a nonzero sample carries again.
  assign sum = ovf ? SAT_VAL : wide[ACC_W-1:0];
`else
  // Plain modular wrap.
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/accum_frame_adder.sv
// Framed two-operand adder/accumulator: one sum per frame of len samples.
// Overflow policy (wrap or clamp) is selected by the ACCUM_SAT_EN macro.
module accum_frame_adder
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ACC_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned S_W = WIDTH + 1;

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             ovf;

  logic [S_W-1:0]   s_raw;
  logic [ACC_W-1:0] s_ext;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] len_eff;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic             out_hs;

  // Sample sum, frame length normalisation and handshake qualifiers.
  assign s_raw   = S_W'(in_a) + S_W'(in_b);
  assign s_ext   = ACC_W'(s_raw);
  assign cnt_nxt = cnt + CNT_W'(1);
  assign len_eff = (len == '0) ? CNT_W'(1) : len;
  assign accept  = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;

  assign in_ready  = !rst && (state != ST_DONE);
  assign out_valid = (state == ST_DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  accum_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc (acc),
    .s   (s_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Frame FSM with accumulator, sample counter, latched length and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc   <= s_ext;
            cnt   <= CNT_W'(1);
            len_q <= len_eff;
            state <= (len_eff == CNT_W'(1)) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= add_sum;
            ovf <= ovf | add_ovf;
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_hs) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_frame_adder.sv
// Bench for accum_frame_adder: two instances (default width and ACC_W=9)
// driven in lockstep and checked against a frame-level arithmetic model.
module tb_accum_frame_adder;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ACC_W0 = 13;
  localparam int unsigned ACC_W1 = 9;

  logic              clk = 1'b0;
  logic              rst, clr, in_valid, out_ready;
  logic [WIDTH-1:0]  in_a, in_b;
  logic [CNT_W-1:0]  len;
  logic              in_ready0, out_valid0, out_ovf0;
  logic              in_ready1, out_valid1, out_ovf1;
  logic [ACC_W0-1:0] out_sum0;
  logic [ACC_W1-1:0] out_sum1;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  accum_frame_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .len(len), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum(out_sum0), .out_ovf(out_ovf0));

  accum_frame_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .len(len), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_ovf(out_ovf1));

  // Frame result from running integer sum: any excursion past 2**aw-1 flags overflow.
  function automatic void ref_frame(input int unsigned aw, input int unsigned av[$],
                                    input int unsigned bv[$], output longint unsigned sum,
                                    output bit ovf);
    longint unsigned maxv = (longint'(1) << aw) - 1;
    longint unsigned run  = 0;
    ovf = 1'b0;
    foreach (av[i]) begin
      run += longint'(av[i]) + longint'(bv[i]);
      if (run > maxv) begin
        ovf = 1'b1;
`ifdef ACCUM_SAT_EN
        run = maxv;
`else
        run = run - (maxv + 1);
`endif
      end
    end
    sum = run;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and hold it until both instances accept it.
  task automatic send_sample(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [CNT_W-1:0] l);
    bit ok = 1'b0;
    in_a = a; in_b = b; len = l; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (in_ready0 && in_ready1) begin ok = 1'b1; break; end
      step();
    end
    total_cnt++;
    if (!ok) $display("FAIL send_timeout in_ready0=%0b in_ready1=%0b exp=1", in_ready0, in_ready1);
    else begin pass_cnt++; step(); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6; len = 4'd1;
    step(); step();
    total_cnt++; if (in_ready0 !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready0); else pass_cnt++;
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid0); else pass_cnt++;
    total_cnt++; if (out_sum0 !== 13'd0) $display("FAIL reset_out_sum got=%0d exp=0", out_sum0); else pass_cnt++;
    total_cnt++; if (out_ovf0 !== 1'b0) $display("FAIL reset_out_ovf got=%0b exp=0", out_ovf0); else pass_cnt++;
    in_valid = 1'b0; rst = 1'b0;
    #1;
    total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL release_in_ready got=%0b exp=1", in_ready0); else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    send_sample(8'd1, 8'd2, 4'd3);
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL basic_early_valid1 got=%0b exp=0", out_valid0); else pass_cnt++;
    send_sample(8'd3, 8'd4, 4'd3);
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL basic_early_valid2 got=%0b exp=0", out_valid0); else pass_cnt++;
    send_sample(8'd5, 8'd6, 4'd3);
    total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL basic_valid got=%0b exp=1", out_valid0); else pass_cnt++;
    total_cnt++; if (out_sum0 !== 13'd21) $display("FAIL basic_sum got=%0d exp=21", out_sum0); else pass_cnt++;
    total_cnt++; if (out_ovf0 !== 1'b0) $display("FAIL basic_ovf got=%0b exp=0", out_ovf0); else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL basic_drain_valid got=%0b exp=0", out_valid0); else pass_cnt++;
    total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL basic_drain_ready got=%0b exp=1", in_ready0); else pass_cnt++;
  endtask

  task automatic test_len_zero();
    send_sample(8'd255, 8'd255, 4'd0);
    total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL len0_valid got=%0b exp=1", out_valid0); else pass_cnt++;
    total_cnt++; if (out_sum0 !== 13'd510) $display("FAIL len0_sum got=%0d exp=510", out_sum0); else pass_cnt++;
    total_cnt++; if (out_sum1 !== 9'd510) $display("FAIL len0_sum_w9 got=%0d exp=510", out_sum1); else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_stall();
    send_sample(8'd10, 8'd20, 4'd1);
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd1; len = 4'd1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (in_ready0 !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", i, in_ready0); else pass_cnt++;
      total_cnt++; if (out_sum0 !== 13'd30) $display("FAIL stall_sum cyc=%0d got=%0d exp=30", i, out_sum0); else pass_cnt++;
      total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%0b exp=1", i, out_valid0); else pass_cnt++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL stall_release_valid got=%0b exp=0", out_valid0); else pass_cnt++;
    total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL stall_release_ready got=%0b exp=1", in_ready0); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int unsigned av[$];
    int unsigned bv[$];
    longint unsigned e0, e1;
    bit o0, o1;
    av = '{255, 255}; bv = '{255, 255};
    ref_frame(ACC_W0, av, bv, e0, o0);
    ref_frame(ACC_W1, av, bv, e1, o1);
    send_sample(8'd255, 8'd255, 4'd2);
    send_sample(8'd255, 8'd255, 4'd2);
    total_cnt++; if (out_sum1 !== ACC_W1'(e1)) $display("FAIL ovf_sum_w9 got=%0d exp=%0d", out_sum1, e1); else pass_cnt++;
    total_cnt++; if (out_ovf1 !== o1) $display("FAIL ovf_flag_w9 got=%0b exp=%0b", out_ovf1, o1); else pass_cnt++;
    total_cnt++; if (out_sum0 !== ACC_W0'(e0)) $display("FAIL ovf_sum_w13 got=%0d exp=%0d", out_sum0, e0); else pass_cnt++;
    total_cnt++; if (out_ovf0 !== o0) $display("FAIL ovf_flag_w13 got=%0b exp=%0b", out_ovf0, o0); else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total_cnt++; if (out_ovf1 !== 1'b0) $display("FAIL ovf_cleared got=%0b exp=0", out_ovf1); else pass_cnt++;
  endtask

  task automatic test_clear();
    send_sample(8'd1, 8'd1, 4'd4);
    send_sample(8'd2, 8'd2, 4'd4);
    clr = 1'b1; in_valid = 1'b1; in_a = 8'd50; in_b = 8'd50;
    step();
    clr = 1'b0; in_valid = 1'b0;
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL clr_valid got=%0b exp=0", out_valid0); else pass_cnt++;
    total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL clr_ready got=%0b exp=1", in_ready0); else pass_cnt++;
    send_sample(8'd7, 8'd1, 4'd1);
    total_cnt++; if (out_sum0 !== 13'd8) $display("FAIL clr_next_sum got=%0d exp=8", out_sum0); else pass_cnt++;
    total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL clr_next_valid got=%0b exp=1", out_valid0); else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_random(input int nframes);
    int unsigned av[$];
    int unsigned bv[$];
    longint unsigned e0, e1;
    bit o0, o1;
    for (int f = 0; f < nframes; f++) begin
      int unsigned l   = $urandom_range(0, 15);
      int unsigned eff = (l == 0) ? 1 : l;
      av.delete(); bv.delete();
      for (int i = 0; i < int'(eff); i++) begin
        int unsigned a = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
        int unsigned b = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
        repeat ($urandom_range(0, 2)) step();
        av.push_back(a); bv.push_back(b);
        // Mid-frame len values are junk and must be ignored.
        send_sample(WIDTH'(a), WIDTH'(b), (i == 0) ? CNT_W'(l) : CNT_W'($urandom));
      end
      ref_frame(ACC_W0, av, bv, e0, o0);
      ref_frame(ACC_W1, av, bv, e1, o1);
      total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL rnd_valid f=%0d got=%0b exp=1", f, out_valid0); else pass_cnt++;
      total_cnt++; if (out_sum0 !== ACC_W0'(e0)) $display("FAIL rnd_sum_w13 f=%0d got=%0d exp=%0d", f, out_sum0, e0); else pass_cnt++;
      total_cnt++; if (out_ovf0 !== o0) $display("FAIL rnd_ovf_w13 f=%0d got=%0b exp=%0b", f, out_ovf0, o0); else pass_cnt++;
      repeat ($urandom_range(0, 3)) step();
      total_cnt++; if (out_sum1 !== ACC_W1'(e1)) $display("FAIL rnd_sum_w9 f=%0d got=%0d exp=%0d", f, out_sum1, e1); else pass_cnt++;
      total_cnt++; if (out_ovf1 !== o1) $display("FAIL rnd_ovf_w9 f=%0d got=%0b exp=%0b", f, out_ovf1, o1); else pass_cnt++;
      out_ready = 1'b1; step(); out_ready = 1'b0;
      total_cnt++; if (out_valid1 !== 1'b0) $display("FAIL rnd_drain f=%0d got=%0b exp=0", f, out_valid1); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_len_zero();
    test_stall();
    test_overflow();
    test_clear();
    test_random(30);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
